// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package pipeline_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0;
  localparam int unsigned INSTR_BYTES     = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry ready/valid skid buffer (output register + one hold entry)
// with a synchronous flush. Empty slots read as all-zero payload.
module fetch_skid_buffer #(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_hold_valid
);

  logic             r_out_valid;
  logic             r_hold_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_hold_data;
  logic             w_consume;

  assign w_consume    = r_out_valid && i_ready;
  assign o_valid      = r_out_valid;
  assign o_data       = r_out_data;
  assign o_hold_valid = r_hold_valid;

  // Buffer update: flush wins, then consume (hold moves forward), then push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_hold_valid <= 1'b0;
      r_out_data   <= '0;
      r_hold_data  <= '0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_hold_valid <= 1'b0;
      r_out_data   <= '0;
      r_hold_data  <= '0;
    end else if (w_consume) begin
      if (r_hold_valid) begin
        r_out_data <= r_hold_data;
        if (i_push) begin
          r_hold_data <= i_push_data;
        end else begin
          r_hold_valid <= 1'b0;
          r_hold_data  <= '0;
        end
      end else if (i_push) begin
        r_out_data <= i_push_data;
      end else begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end
    end else if (i_push) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_push_data;
      end else if (!r_hold_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= i_push_data;
      end
    end
  end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: keeps the PC, issues one aligned read at a time,
// selects the instruction half and hands (instruction, pc) to decode.
module pipeline_fetch
  import pipeline_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic [DATA_WIDTH/2-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]   instruction_pc,
  input  logic                    next_stage_ready,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  input  logic                    halt
);

  localparam int unsigned IW = DATA_WIDTH / 2;
  localparam int unsigned PW = IW + ADDR_WIDTH;

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_squash;

  logic                  w_req_fire;
  logic                  w_resp;
  logic                  w_push;
  logic                  w_hold_valid;
  logic                  w_out_valid;
  logic [IW-1:0]         w_instr;
  logic [PW-1:0]         w_push_data;
  logic [PW-1:0]         w_out_data;
  logic [ADDR_WIDTH-1:0] w_redirect_target;
  logic [1:0]            w_unused_redirect_lsbs;

  assign w_req_fire             = mem_req_valid && mem_req_ready;
  assign w_resp                 = (r_state == S_WAIT) && mem_resp_valid;
  assign w_push                 = w_resp && !r_squash && !redirect_valid;
  assign w_redirect_target      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_redirect_lsbs = redirect_pc[1:0];
  assign w_instr                = r_req_pc[2] ? mem_resp_data[DATA_WIDTH-1:IW]
                                              : mem_resp_data[IW-1:0];
  assign w_push_data            = {r_req_pc, w_instr};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a redirect with a concurrent response also returns to S_REQ.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_req_fire) w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_resp_valid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Request outputs, forced low while reset is held.
  always_comb begin
    mem_req_valid = reset && (r_state == S_REQ) && !w_hold_valid
                    && !halt && !redirect_valid;
    mem_req_addr  = {r_pc[ADDR_WIDTH-1:3], 3'b000};
  end

  // PC, request PC and squash tracking; redirect overrides sequential update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_squash <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= w_redirect_target;
      r_squash <= (r_state == S_WAIT) && !mem_resp_valid;
    end else begin
      if (w_req_fire) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
      end
      if (w_resp) begin
        r_squash <= 1'b0;
      end
    end
  end

  fetch_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .clk          (clk),
    .rst_n        (reset),
    .i_flush      (redirect_valid),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_ready      (next_stage_ready),
    .o_valid      (w_out_valid),
    .o_data       (w_out_data),
    .o_hold_valid (w_hold_valid)
  );

  // Empty slots are cleared inside the buffer, so the payload already reads 0.
  always_comb begin
    instruction    = w_out_valid ? w_out_data[IW-1:0]  : NOP_INSTRUCTION[IW-1:0];
    instruction_pc = w_out_valid ? w_out_data[PW-1:IW] : '0;
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
module tb_pipeline_fetch;

  localparam int unsigned   AW     = 64;
  localparam int unsigned   DW     = 64;
  localparam logic [AW-1:0] RST_PC = 64'h1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [31:0]   instruction;
  logic [AW-1:0] instruction_pc;
  logic          next_stage_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;

  always #5 clk = ~clk;

  pipeline_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .instruction     (instruction),
    .instruction_pc  (instruction_pc),
    .next_stage_ready(next_stage_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got=timeout expected=event", name);
  endtask

  // Program image: the instruction at byte address a is C0DE_xxxx with a's low 16 bits.
  function automatic logic [31:0] imem(input logic [AW-1:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [AW-1:0] lo, hi;
    lo = {a[AW-1:3], 3'b000};
    hi = {a[AW-1:3], 3'b100};
    return {imem(hi), imem(lo)};
  endfunction

  // Memory: responds lat cycles after the accept cycle's following cycle.
  int            lat = 0;
  bit            acc_seen = 0;
  logic [AW-1:0] acc_addr;
  bit            outst = 0;
  int            cnt = 0;
  logic [AW-1:0] mem_addr;

  always @(negedge clk) begin
    acc_seen = reset && mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (!reset) begin
      outst    = 0;
      acc_seen = 0;
    end else begin
      if (acc_seen) begin
        outst    = 1;
        cnt      = lat;
        mem_addr = acc_addr;
        acc_seen = 0;
      end
      if (outst) begin
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = word(mem_addr);
          outst          = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Reference model: program-order stream from the last reset/redirect.
  int            cyc = 0;
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] fpc;
  logic [AW-1:0] req_log[$];
  logic [AW-1:0] con_pc[$];
  logic [31:0]   con_ins[$];
  int            con_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      exp_pc = RST_PC;
      fpc    = RST_PC;
      chk("reset_instr", 64'(instruction), 64'h0);
      chk("reset_pc", instruction_pc, 64'h0);
      chk("reset_req_valid", 64'(mem_req_valid), 64'h0);
    end else begin
      if (halt || redirect_valid) chk("req_gated", 64'(mem_req_valid), 64'h0);
      if (mem_req_valid) chk("req_addr", mem_req_addr, {fpc[AW-1:3], 3'b000});
      if (mem_req_valid && mem_req_ready) begin
        req_log.push_back(mem_req_addr);
        fpc = fpc + 4;
      end
      if (instruction_pc == '0) begin
        chk("empty_instr", 64'(instruction), 64'h0);
      end else if (next_stage_ready) begin
        chk("deliver_pc", instruction_pc, exp_pc);
        chk("deliver_instr", 64'(instruction), 64'(imem(exp_pc)));
        con_pc.push_back(instruction_pc);
        con_ins.push_back(instruction);
        con_cyc.push_back(cyc);
        exp_pc = exp_pc + 4;
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[AW-1:2], 2'b00};
        fpc    = {redirect_pc[AW-1:2], 2'b00};
      end
    end
  end

  task automatic wait_cons(input int n, input string name);
    int t = 0;
    while (con_pc.size() < n && t < 80) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (con_pc.size() < n) timeout_fail(name);
  endtask

  task automatic wait_acc(input bit need_full, input string name);
    int t = 0;
    int n;
    bit ok = 0;
    while (!ok && t < 80) begin
      n = req_log.size();
      @(negedge clk);
      #1;
      t++;
      if (req_log.size() > n && (!need_full || instruction_pc != '0)) ok = 1;
    end
    if (!ok) timeout_fail(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int r0, c0;
    logic [AW-1:0] p;
    reset            = 1'b0;
    next_stage_ready = 1'b1;
    halt             = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    mem_req_ready    = 1'b1;
    mem_resp_valid   = 1'b0;
    mem_resp_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("first_req_valid", 64'(mem_req_valid), 64'h1);
    chk("first_req_addr", mem_req_addr, 64'h1000);

    // Sequential fetch, zero-wait memory, decode always ready.
    wait_cons(4, "seq_timeout");
    chk("seq_req0", req_log[0], 64'h1000);
    chk("seq_req1", req_log[1], 64'h1000);
    chk("seq_req2", req_log[2], 64'h1008);
    chk("seq_req3", req_log[3], 64'h1008);
    chk("seq_pc0", con_pc[0], 64'h1000);
    chk("seq_pc1", con_pc[1], 64'h1004);
    chk("seq_pc2", con_pc[2], 64'h1008);
    chk("seq_pc3", con_pc[3], 64'h100C);
    chk("seq_lo0", 64'(con_ins[0]), 64'hC0DE1000);
    chk("seq_hi1", 64'(con_ins[1]), 64'hC0DE1004);
    chk("seq_lo2", 64'(con_ins[2]), 64'hC0DE1008);
    chk("seq_hi3", 64'(con_ins[3]), 64'hC0DE100C);
    chk("seq_rate1", 64'(con_cyc[1] - con_cyc[0]), 64'd2);
    chk("seq_rate2", 64'(con_cyc[2] - con_cyc[1]), 64'd2);

    // Back-pressure: buffer fills with two entries, then requests stop.
    @(posedge clk);
    #1;
    next_stage_ready = 1'b0;
    c0 = con_pc.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (i >= 3) chk("stall_no_req", 64'(mem_req_valid), 64'h0);
      @(posedge clk);
      #1;
    end
    next_stage_ready = 1'b1;
    wait_cons(c0 + 3, "stall_timeout");
    chk("stall_b2b", 64'(con_cyc[c0+1] - con_cyc[c0]), 64'd1);
    chk("stall_refill", 64'(con_cyc[c0+2] - con_cyc[c0+1]), 64'd2);
    chk("stall_order", con_pc[c0+1] - con_pc[c0], 64'd4);

    // Redirect while waiting on a slow response.
    lat = 2;
    wait_acc(1'b0, "redir_wait_timeout");
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    lat            = 0;
    r0 = req_log.size();
    c0 = con_pc.size();
    wait_cons(c0 + 1, "redir_wait_cons");
    chk("redir_wait_req", req_log[r0], 64'h2000);
    chk("redir_wait_pc", con_pc[c0], 64'h2000);

    // Redirect coinciding with a response while the output slot is full.
    @(posedge clk);
    #1;
    next_stage_ready = 1'b0;
    wait_acc(1'b1, "redir_resp_timeout");
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    r0 = req_log.size();
    chk("redir_resp_flush_pc", instruction_pc, 64'h0);
    chk("redir_resp_flush_ins", 64'(instruction), 64'h0);
    next_stage_ready = 1'b1;
    c0 = con_pc.size();
    wait_cons(c0 + 1, "redir_resp_cons");
    chk("redir_resp_req", req_log[r0], 64'h3000);
    chk("redir_resp_pc", con_pc[c0], 64'h3000);

    // Halt asserted in S_WAIT: pending instruction delivered, then silence.
    wait_acc(1'b0, "halt_timeout");
    @(posedge clk);
    #1;
    halt = 1'b1;
    r0 = req_log.size();
    c0 = con_pc.size();
    repeat (12) @(posedge clk);
    #1;
    chk("halt_no_req", 64'(req_log.size() - r0), 64'd0);
    chk("halt_delivered", 64'(con_pc.size() - c0), 64'd1);
    p = con_pc[c0];
    halt = 1'b0;
    wait_cons(c0 + 2, "halt_resume_timeout");
    chk("halt_resume_req", req_log[r0], {p[AW-1:3], 3'b000} + ((p[2] == 1'b1) ? 64'd8 : 64'd0));
    chk("halt_resume_pc", con_pc[c0+1], p + 64'd4);

    // Asynchronous reset in S_WAIT with an instruction buffered.
    @(posedge clk);
    #1;
    next_stage_ready = 1'b0;
    lat = 2;
    wait_acc(1'b1, "rst_wait_timeout");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_ins", 64'(instruction), 64'h0);
    chk("async_rst_pc", instruction_pc, 64'h0);
    chk("async_rst_req", 64'(mem_req_valid), 64'h0);
    lat = 0;
    next_stage_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    r0 = req_log.size();
    c0 = con_pc.size();
    wait_cons(c0 + 1, "rst_restart_timeout");
    chk("rst_restart_req", req_log[r0], 64'h1000);
    chk("rst_restart_pc", con_pc[c0], 64'h1000);
    chk("rst_restart_ins", 64'(con_ins[c0]), 64'hC0DE1000);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_fetch.md
# pipeline_fetch

- Instruction-fetch stage that feeds `pipeline_decode`.
- Keeps the program counter and issues one aligned 64-bit read per instruction to instruction memory, with at most one read outstanding.
- Selects the 32-bit instruction half from each read and presents it with its PC to decode through a ready/valid skid buffer.
- Handles redirects from execute: flushes buffered instructions and squashes the stale in-flight response. Stops fetching on `halt`.

## Interface
- `ADDR_WIDTH`, 64: PC and memory address width.
- `DATA_WIDTH`, 64: memory read data width. The instruction width is `DATA_WIDTH/2`.
- `RESET_PC`, 0: PC loaded on reset. Must be a multiple of 4.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low (0 = in reset).
- `mem_req_valid` output 1: read request valid.
- `mem_req_addr` output ADDR_WIDTH: request address, `{pc[ADDR_WIDTH-1:3], 3'b000}`.
- `mem_req_ready` input 1: memory accepts the request this cycle.
- `mem_resp_valid` input 1: read data valid for one cycle. Cannot be back-pressured.
- `mem_resp_data` input DATA_WIDTH: read data.
- `instruction` output DATA_WIDTH/2: instruction to decode. Reads 0 (NOP) when the output slot is empty.
- `instruction_pc` output ADDR_WIDTH: PC of `instruction`. Reads 0 when the output slot is empty.
- `next_stage_ready` input 1: decode `ready`. The output slot is consumed when it is occupied and this input is 1.
- `redirect_valid` input 1: one-cycle pulse from execute (taken branch or jump).
- `redirect_pc` input ADDR_WIDTH: redirect target. Bits [1:0] are ignored (forced to 0).
- `halt` input 1: ecall reached. Level signal; while 1, no new requests are issued.

## Operation
- FSM states and transitions:
  - `S_REQ`: `mem_req_valid = !hold_valid && !halt && !redirect_valid`. On `mem_req_valid && mem_req_ready`:
    - `req_pc <= pc`
    - `pc <= pc + 4` (wraps modulo 2^ADDR_WIDTH)
    - go to `S_WAIT`.
  - `S_WAIT`: `mem_req_valid = 0`. On `mem_resp_valid`, return to `S_REQ`.
    - If `squash` is set: discard the data and clear `squash`.
    - Otherwise the instruction is `mem_resp_data[31:0]` when `req_pc[2]==0`, else `mem_resp_data[63:32]`. Pair it with `req_pc` and push it into the skid buffer.
- Skid buffer: output register (`out_valid`) plus one hold entry (`hold_valid`).
  - A push goes to the output register if `!out_valid || next_stage_ready`, otherwise to the hold entry.
  - On consume with `hold_valid`, the hold entry moves to the output register.
  - On consume without `hold_valid` and without a push, `out_valid <= 0`.
  - A push while the hold entry is full cannot occur: requests are gated on `!hold_valid`.
- Redirect (`redirect_valid = 1`) has priority over every other event in the same cycle:
  - `pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}`.
  - `out_valid <= 0` and `hold_valid <= 0`.
  - A consume in the same cycle is still counted by decode, but no data is moved.
  - In `S_WAIT` without a response this cycle: `squash <= 1`.
  - In `S_WAIT` with a response this cycle: the response is discarded, go to `S_REQ`, `squash <= 0`.
- Halt: an outstanding request completes and is buffered normally. `pc` does not advance while `halt` is 1. Fetch resumes when `halt` returns to 0.
- A fetched instruction word of 0 is forwarded unchanged; decode treats it as NOP.

## Timing
- Reset values (asynchronous, while `reset == 0`):
  - state `S_REQ`, `pc = RESET_PC`.
  - `req_pc`, `out_valid`, `hold_valid`, `squash` all 0.
  - `instruction = 0`, `instruction_pc = 0`.
  - `mem_req_valid = 0` (forced while in reset).
- `mem_req_valid` rises in the first cycle after `reset` deasserts.
- Request accepted at edge N means the response can arrive in cycle N+1 at the earliest. A response sampled at edge M is visible on `instruction` in cycle M+1.
- Peak throughput is one instruction per 2 cycles (zero-wait memory, decode always ready).
- `mem_req_addr` and `mem_req_valid` are combinational from state, `pc`, `hold_valid`, `halt` and `redirect_valid`. All other outputs are registered.
- Asserting reset mid-operation drops any outstanding request. A response arriving after reset deasserts while the FSM is in `S_REQ` is ignored.

## Structure
- The package `pipeline_pkg` holds:
  - `fetch_state_t` (`S_REQ`, `S_WAIT`)
  - `NOP_INSTRUCTION = 32'h0`
  - `INSTR_BYTES = 4`
- Sub-module `fetch_skid_buffer`: the two-entry ready/valid buffer with flush. It is parameterized on payload width (instruction + PC).

## Test plan
- Reset with `RESET_PC = 'h1000`, zero-wait memory, decode always ready: requests go to addresses 1000, 1000, 1008, 1008; decode sees PCs 1000, 1004, 1008, 100C on every other cycle. The halves selected are low, high, low, high.
- Hold `next_stage_ready = 0` for 6 cycles: exactly two instructions are buffered, `mem_req_valid` stays 0, and no instruction is lost or duplicated after release.
- Redirect to `'h2002` while in `S_WAIT`: the next response is discarded, the next request address is 2000, and decode next sees PC 2000.
- Redirect in the same cycle as `mem_resp_valid` while the output slot is full: both buffer entries are flushed, the response is dropped, and the following request targets the redirect PC.
- With `halt = 1` asserted in `S_WAIT`: the pending instruction is delivered, then there are no requests for 10 cycles. After release, fetch resumes at the next sequential PC.
- Reset asserted while in `S_WAIT` with a buffered instruction: `instruction = 0` and `instruction_pc = 0` immediately (asynchronous reset), and fetch restarts at `RESET_PC`.
